toggle_pattern_checker: RTL and testbench
=========================================

Name: toggle_pattern_checker

Overview:
- Receive-side checker for the per-bit toggle pattern source, where every bit of a generated bus inverts on each sample.
- Samples a WIDTH-bit bus and verifies that every bit inverts relative to the previous accepted sample.
- Acquires lock, then counts and localises errors; drops lock on persistent errors.
- Sits on the sink side of generate-loop pattern sources in TMR/SEU test structures.

Parameters:
- WIDTH, 32, monitored bus width.
- LOCK_CNT, 4, consecutive good transitions required to lock (>=1).
- UNLOCK_CNT, 2, consecutive bad transitions while locked that force loss of lock (>=1).
- ERRW, 16, error counter width.

Ports:
- c  input  1  clock, rising edge.
- r  input  1  reset; synchronous, active-low.
- d  input  WIDTH  monitored pattern bus.
- valid  input  1  d is sampled on this edge when high.
- clr  input  1  clears err_cnt and err_mask; FSM unaffected.
- locked  output  1  high while FSM is in LOCKED.
- err  output  1  one-cycle pulse per bad transition detected in LOCKED.
- err_mask  output  WIDTH  sticky OR of failing bit positions.
- err_cnt  output  ERRW  saturating count of bad transitions.

Behaviour:
- Reset (r==0 at edge): FSM=IDLE; prev, good_cnt, bad_cnt=0; locked=0, err=0, err_mask=0, err_cnt=0. Reset overrides all other inputs.
- Only edges with valid=1 are evaluated. With valid=0, all state holds and err=0.
- Transition check on a valid sample: bad_bits = ~(d ^ prev). A bit is bad if it did not invert. Sample is good iff bad_bits==0.
- prev<=d on every valid sample in every state (realigns to the source).
- IDLE: valid -> capture prev, go SYNC, good_cnt=0. No check is made.
- SYNC:
  - good: if good_cnt==LOCK_CNT-1 go LOCKED with bad_cnt=0, else good_cnt++.
  - bad: good_cnt=0, stay in SYNC.
  - No errors are reported in SYNC.
- LOCKED:
  - good: bad_cnt=0.
  - bad: err=1 next cycle; err_mask|=bad_bits; err_cnt+=1 saturating at 2^ERRW-1; bad_cnt++.
  - If bad_cnt reaches UNLOCK_CNT (i.e. bad with bad_cnt==UNLOCK_CNT-1): go SYNC, good_cnt=0. The causing error is still counted.
- All outputs are registered. locked, err, err_mask and err_cnt reflect a sample one clock after the sampling edge.
- clr together with an error on the same edge: clear first, then apply the error (err_cnt=1, err_mask=bad_bits).
- A single-bit glitch yields two consecutive bad transitions, because prev realigns to the glitched value. This is intended behaviour.

Optional Feature:
- Macro TOGGLE_PATTERN_CHECKER_FIRST_ERR_EN.
- Defined:
  - Adds output first_err [WIDTH-1:0] and an internal captured flag.
  - On the first LOCKED error after reset or clr, first_err<=d and the flag is set.
  - Later errors do not update first_err.
  - clr or reset zeroes first_err and the flag.
  - clr together with an error: capture this d.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Lock acquisition (default parameters): after reset, valid=1 with d alternating 0x00000000/0xFFFFFFFF from 0x00000000. FSM goes IDLE->SYNC on sample 1. locked=1 the cycle after sample 5. err never asserts, err_cnt=0.
- Glitch while locked: prev=0x00000000, send 0xFFFFFFFE then resume 0x00000000, 0xFFFFFFFF.
  - err pulses on two consecutive cycles; err_cnt=2, err_mask=0x00000001.
  - locked drops after the second error, then relocks after 4 further good transitions.
- Valid gaps: while locked, hold valid=0 for 10 cycles with d=0x12345678, then resume the correct inverting sequence. locked stays 1, err stays 0, and there is no error on resume.
- clr collision: with err_cnt=5 and err_mask=0x00000003, apply clr on the same edge as a bad sample with bad_bits=0x00000100. Result: err_cnt=1, err_mask=0x00000100.
- Saturation: ERRW=4, UNLOCK_CNT=100, locked; send 20 non-inverting samples. err_cnt=15 and holds; err pulses 20 times.
- Mid-operation reset: while locked with err_cnt=3, drive r=0 for 1 cycle. All outputs are 0 next cycle. The first valid sample afterwards only captures, even if it matches the old prev; no err.

Source files
------------

// File: rtl/toggle_pattern_checker_if.sv
// Bus bundle for the toggle pattern checker: monitored data, strobes and status.
// master drives d/valid/clr and reads status; slave is the checker side.
// Optional first_err is present when TOGGLE_PATTERN_CHECKER_FIRST_ERR_EN is defined.
interface toggle_pattern_checker_if #(
    parameter int WIDTH = 32,
    parameter int ERRW  = 16
);
    logic [WIDTH-1:0] d;
    logic             valid;
    logic             clr;
    logic             locked;
    logic             err;
    logic [WIDTH-1:0] err_mask;
    logic [ERRW-1:0]  err_cnt;
`ifdef TOGGLE_PATTERN_CHECKER_FIRST_ERR_EN
    logic [WIDTH-1:0] first_err;

    modport master (
        output d, valid, clr,
        input  locked, err, err_mask, err_cnt, first_err
    );
    modport slave (
        input  d, valid, clr,
        output locked, err, err_mask, err_cnt, first_err
    );
`else
    modport master (
        output d, valid, clr,
        input  locked, err, err_mask, err_cnt
    );
    modport slave (
        input  d, valid, clr,
        output locked, err, err_mask, err_cnt
    );
`endif
endinterface

// File: rtl/toggle_pattern_checker.sv
// Toggle pattern checker: every bit of d must invert on each valid sample.
// Ports: c clock, r sync active-low reset, bus (slave) carries d/valid/clr in,
// locked/err/err_mask/err_cnt out (+first_err if TOGGLE_PATTERN_CHECKER_FIRST_ERR_EN).
module toggle_pattern_checker #(
    parameter int WIDTH      = 32,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int ERRW       = 16
) (
    input logic                  c,
    input logic                  r,
    toggle_pattern_checker_if.slave bus
);

    localparam int GW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int BW = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT) : 1;
    localparam logic [GW-1:0] GLAST = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] BLAST = BW'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [GW-1:0]    good_cnt;
    logic [BW-1:0]    bad_cnt;
    logic             locked_q;
    logic             err_q;
    logic [WIDTH-1:0] mask_q;
    logic [ERRW-1:0]  cnt_q;

    logic [WIDTH-1:0] bad_bits;
    logic             good;
    logic [WIDTH-1:0] mask_base;
    logic [ERRW-1:0]  cnt_base;
    logic [ERRW-1:0]  cnt_inc;

    // A bit is bad when it failed to invert against the last accepted sample.
    assign bad_bits = ~(bus.d ^ prev);
    assign good     = (bad_bits == '0);

    // clr on the same edge as an error: clear first, then accumulate.
    assign mask_base = bus.clr ? '0 : mask_q;
    assign cnt_base  = bus.clr ? '0 : cnt_q;
    assign cnt_inc   = (&cnt_base) ? cnt_base : cnt_base + ERRW'(1);

`ifdef TOGGLE_PATTERN_CHECKER_FIRST_ERR_EN
    logic [WIDTH-1:0] first_q;
    logic             cap_q;
    logic             cap_base;

    assign cap_base      = cap_q & ~bus.clr;
    assign bus.first_err = first_q;
`endif

    always_ff @(posedge c) begin
        if (!r) begin
            state    <= IDLE;
            prev     <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            mask_q   <= '0;
            cnt_q    <= '0;
`ifdef TOGGLE_PATTERN_CHECKER_FIRST_ERR_EN
            first_q  <= '0;
            cap_q    <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
            if (bus.clr) begin
                mask_q <= '0;
                cnt_q  <= '0;
`ifdef TOGGLE_PATTERN_CHECKER_FIRST_ERR_EN
                first_q <= '0;
                cap_q   <= 1'b0;
`endif
            end
            if (bus.valid) begin
                // Always realign to the source, whatever the verdict.
                prev <= bus.d;
                unique case (state)
                    IDLE: begin
                        state    <= SYNC;
                        good_cnt <= '0;
                    end
                    SYNC: begin
                        if (!good) begin
                            good_cnt <= '0;
                        end else if (good_cnt == GLAST) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_cnt + GW'(1);
                        end
                    end
                    LOCKED: begin
                        if (good) begin
                            bad_cnt <= '0;
                        end else begin
                            err_q  <= 1'b1;
                            mask_q <= mask_base | bad_bits;
                            cnt_q  <= cnt_inc;
`ifdef TOGGLE_PATTERN_CHECKER_FIRST_ERR_EN
                            if (!cap_base) begin
                                first_q <= bus.d;
                                cap_q   <= 1'b1;
                            end
`endif
                            if (bad_cnt == BLAST) begin
                                state    <= SYNC;
                                locked_q <= 1'b0;
                                good_cnt <= '0;
                            end else begin
                                bad_cnt <= bad_cnt + BW'(1);
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked   = locked_q;
    assign bus.err      = err_q;
    assign bus.err_mask = mask_q;
    assign bus.err_cnt  = cnt_q;

endmodule

// File: tb/tb_toggle_pattern_checker.sv
// Bench for toggle_pattern_checker: default instance u0 and a saturation
// instance u1 (ERRW=4, UNLOCK_CNT=100), checked against a reference model.
module tb_toggle_pattern_checker;

    logic c;
    logic r;

    initial c = 1'b0;
    always #5 c = ~c;

    toggle_pattern_checker_if #(.WIDTH(32), .ERRW(16)) b0 ();
    toggle_pattern_checker_if #(.WIDTH(32), .ERRW(4))  b1 ();

    toggle_pattern_checker u0 (
        .c   (c),
        .r   (r),
        .bus (b0.slave)
    );

    toggle_pattern_checker #(
        .WIDTH      (32),
        .LOCK_CNT   (4),
        .UNLOCK_CNT (100),
        .ERRW       (4)
    ) u1 (
        .c   (c),
        .r   (r),
        .bus (b1.slave)
    );

    typedef struct {
        int          st;
        int          gc;
        int          bc;
        int          cnt;
        logic [31:0] prev;
        logic [31:0] mask;
        logic [31:0] first;
        bit          err;
        bit          cap;
    } mst_t;

    mst_t m0, m1;
    mst_t q0[$];
    mst_t q1[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: st 0=IDLE 1=SYNC 2=LOCKED.
    function automatic mst_t step(mst_t s, bit v, bit cl, logic [31:0] dd,
                                  int lk, int ul, int cmax);
        mst_t n = s;
        logic [31:0] bb;
        n.err = 1'b0;
        if (cl) begin
            n.mask  = '0;
            n.cnt   = 0;
            n.cap   = 1'b0;
            n.first = '0;
        end
        if (v) begin
            bb = ~(dd ^ s.prev);
            n.prev = dd;
            if (s.st == 0) begin
                n.st = 1;
                n.gc = 0;
            end else if (s.st == 1) begin
                if (bb != 0) n.gc = 0;
                else if (s.gc == lk - 1) begin
                    n.st = 2;
                    n.bc = 0;
                end else n.gc = s.gc + 1;
            end else begin
                if (bb == 0) n.bc = 0;
                else begin
                    n.err  = 1'b1;
                    n.mask = n.mask | bb;
                    if (n.cnt < cmax) n.cnt = n.cnt + 1;
                    if (!n.cap) begin
                        n.cap   = 1'b1;
                        n.first = dd;
                    end
                    if (s.bc == ul - 1) begin
                        n.st = 1;
                        n.gc = 0;
                    end else n.bc = s.bc + 1;
                end
            end
        end
        return n;
    endfunction

    task automatic cmp(string n, mst_t e, logic lk, logic er,
                       logic [31:0] mk, logic [31:0] ct);
        check({n, ".locked"}, 32'(lk), 32'(e.st == 2));
        check({n, ".err"}, 32'(er), 32'(e.err));
        check({n, ".err_mask"}, mk, e.mask);
        check({n, ".err_cnt"}, ct, 32'(e.cnt));
    endtask

    task automatic cyc();
        mst_t e;
        if (!r) begin
            m0 = '{default: 0};
            m1 = '{default: 0};
        end else begin
            m0 = step(m0, b0.valid, b0.clr, b0.d, 4, 2, 65535);
            m1 = step(m1, b1.valid, b1.clr, b1.d, 4, 100, 15);
        end
        q0.push_back(m0);
        q1.push_back(m1);
        @(posedge c);
        #1;
        e = q0.pop_front();
        cmp("u0", e, b0.locked, b0.err, b0.err_mask, 32'(b0.err_cnt));
`ifdef TOGGLE_PATTERN_CHECKER_FIRST_ERR_EN
        check("u0.first_err", b0.first_err, e.first);
`endif
        e = q1.pop_front();
        cmp("u1", e, b1.locked, b1.err, b1.err_mask, 32'(b1.err_cnt));
    endtask

    task automatic s0(logic [31:0] dd, bit v, bit cl);
        b0.d = dd;
        b0.valid = v;
        b0.clr = cl;
        cyc();
        b0.valid = 1'b0;
        b0.clr = 1'b0;
    endtask

    task automatic s1(logic [31:0] dd, bit v);
        b1.d = dd;
        b1.valid = v;
        cyc();
        b1.valid = 1'b0;
    endtask

    task automatic good0();
        s0(~m0.prev, 1'b1, 1'b0);
    endtask

    task automatic bad0(logic [31:0] bits, bit cl);
        s0(~m0.prev ^ bits, 1'b1, cl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [31:0] oldp;
        r = 1'b0;
        b0.d = '0;
        b0.valid = 1'b0;
        b0.clr = 1'b0;
        b1.d = '0;
        b1.valid = 1'b0;
        b1.clr = 1'b0;
        cyc();
        cyc();
        check("rst_locked", 32'(b0.locked), 32'd0);
        check("rst_cnt", 32'(b0.err_cnt), 32'd0);
        check("rst_mask", b0.err_mask, 32'd0);
        r = 1'b1;

        // Lock acquisition: 0, F, 0, F, 0
        for (int i = 0; i < 5; i++) begin
            s0((i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0, 1'b1, 1'b0);
            if (i == 3) check("lock_s4", 32'(b0.locked), 32'd0);
        end
        check("lock_s5", 32'(b0.locked), 32'd1);
        check("lock_cnt", 32'(b0.err_cnt), 32'd0);

        // Single-bit glitch gives two bad transitions
        s0(32'hFFFF_FFFE, 1'b1, 1'b0);
        check("glitch_err1", 32'(b0.err), 32'd1);
        s0(32'h0, 1'b1, 1'b0);
        check("glitch_err2", 32'(b0.err), 32'd1);
        check("glitch_cnt", 32'(b0.err_cnt), 32'd2);
        check("glitch_mask", b0.err_mask, 32'h1);
        check("glitch_unlock", 32'(b0.locked), 32'd0);
        for (int i = 0; i < 4; i++) begin
            s0((i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0, 1'b1, 1'b0);
            if (i == 2) check("relock_early", 32'(b0.locked), 32'd0);
        end
        check("relock", 32'(b0.locked), 32'd1);

        // Valid gaps
        for (int i = 0; i < 10; i++) s0(32'h1234_5678, 1'b0, 1'b0);
        check("gap_locked", 32'(b0.locked), 32'd1);
        check("gap_err", 32'(b0.err), 32'd0);
        s0(32'hFFFF_FFFF, 1'b1, 1'b0);
        check("resume_err", 32'(b0.err), 32'd0);
        s0(32'h0, 1'b1, 1'b0);
        check("resume_cnt", 32'(b0.err_cnt), 32'd2);

        // Build err_cnt=5, err_mask=3, then clr collides with an error
        bad0(32'h2, 1'b0);
        good0();
        bad0(32'h1, 1'b0);
        good0();
        bad0(32'h2, 1'b0);
        good0();
        check("pre_clr_cnt", 32'(b0.err_cnt), 32'd5);
        check("pre_clr_mask", b0.err_mask, 32'h3);
        bad0(32'h100, 1'b1);
        check("clr_cnt", 32'(b0.err_cnt), 32'd1);
        check("clr_mask", b0.err_mask, 32'h100);
        check("clr_locked", 32'(b0.locked), 32'd1);
        good0();

        // Mid-operation reset
        bad0(32'h1, 1'b0);
        good0();
        bad0(32'h1, 1'b0);
        good0();
        check("prerst_cnt", 32'(b0.err_cnt), 32'd3);
        oldp = m0.prev;
        r = 1'b0;
        cyc();
        r = 1'b1;
        check("mrst_locked", 32'(b0.locked), 32'd0);
        check("mrst_cnt", 32'(b0.err_cnt), 32'd0);
        check("mrst_mask", b0.err_mask, 32'd0);
        check("mrst_err", 32'(b0.err), 32'd0);
        s0(~oldp, 1'b1, 1'b0);
        check("post_rst_err", 32'(b0.err), 32'd0);
        check("post_rst_locked", 32'(b0.locked), 32'd0);
        s0(oldp, 1'b1, 1'b0);
        check("post_rst_err2", 32'(b0.err), 32'd0);

        // Saturation on u1
        for (int i = 0; i < 5; i++)
            s1((i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0, 1'b1);
        check("sat_locked", 32'(b1.locked), 32'd1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            s1(m1.prev, 1'b1);
            if (b1.err === 1'b1) pulses++;
        end
        check("sat_pulses", 32'(pulses), 32'd20);
        check("sat_cnt", 32'(b1.err_cnt), 32'd15);
        s1(32'h0, 1'b0);
        check("sat_hold_cnt", 32'(b1.err_cnt), 32'd15);
        check("sat_hold_err", 32'(b1.err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
